// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl: frame sequencer driving the N-lane softmax datapath.
// Credit-based issue (inflight + FIFO occupancy < DEPTH) so no result is
// ever dropped under downstream backpressure; results drain via a FIFO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, frame_len  begin a frame of frame_len vectors (IDLE only)
//   s_valid/s_ready/s_data          upstream vector stream
//   dp_en/dp_valid_in/dp_in_x_flat  datapath issue side
//   dp_valid_out/dp_out_flat        datapath result side
//   m_valid/m_ready/m_data/m_last   downstream result stream
//   busy, done, err_overflow        status
// Optional: define SOFTMAX_SEQ_STATS_EN to add stat_stall / stat_frames.
module softmax_seq_ctrl #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int LAT   = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [15:0]    frame_len,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [N*W-1:0] s_data,
    output logic           dp_en,
    output logic           dp_valid_in,
    output logic [N*W-1:0] dp_in_x_flat,
    input  logic           dp_valid_out,
    input  logic [N*W-1:0] dp_out_flat,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [N*W-1:0] m_data,
    output logic           m_last,
    output logic           busy,
    output logic           done,
    output logic           err_overflow
`ifdef SOFTMAX_SEQ_STATS_EN
   ,output logic [31:0]    stat_stall,
    output logic [15:0]    stat_frames
`endif
);

    localparam int DW   = N * W;
    localparam int PW   = $clog2(DEPTH);
    // inflight can never exceed min(LAT, DEPTH); size for the larger.
    localparam int CMAX = (LAT > DEPTH) ? LAT : DEPTH;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    logic [15:0]   len_q;
    logic [15:0]   issued;
    logic [15:0]   popped;
    logic [CW-1:0] inflight;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight_nx;
    logic [CW-1:0] count_nx;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] mem [DEPTH];

    logic credit_ok;
    logic issue;
    logic ret_ok;
    logic full;
    logic pop;
    logic push;
    logic err_set;
    logic drain_done;

    always_comb begin
        credit_ok    = ({1'b0, inflight} + {1'b0, count}) < (CW + 1)'(DEPTH);
        s_ready      = (state == RUN) && credit_ok;
        issue        = s_valid && s_ready;
        dp_valid_in  = issue;
        dp_in_x_flat = issue ? s_data : '0;
        dp_en        = (state == RUN) || (state == DRAIN);
        busy         = (state != IDLE);
        m_valid      = (count != '0);
        pop          = m_valid && m_ready;
        full         = (count == CW'(DEPTH));
        // A result with nothing outstanding is spurious and dropped.
        ret_ok       = dp_valid_out && (inflight != '0);
        push         = ret_ok && (!full || pop);
        err_set      = dp_valid_out && !push;
        inflight_nx  = inflight + CW'(issue) - CW'(ret_ok);
        count_nx     = count + CW'(push) - CW'(pop);
        // Look ahead so done follows the final pop by one cycle.
        drain_done   = (state == DRAIN) && (inflight_nx == '0)
                       && (count_nx == '0);
        m_data       = m_valid ? mem[rd_ptr] : '0;
        m_last       = m_valid && (popped == len_q - 16'd1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dp_out_flat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= '0;
            issued       <= '0;
            popped       <= '0;
            inflight     <= '0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            inflight <= inflight_nx;
            count    <= count_nx;
            done     <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                popped <= popped + 16'd1;
            end
            if (issue) begin
                issued <= issued + 16'd1;
            end
            if (err_set) begin
                err_overflow <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (frame_len != 16'd0) begin
                            state  <= RUN;
                            len_q  <= frame_len;
                            issued <= '0;
                            popped <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && (issued == len_q - 16'd1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SOFTMAX_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall  <= '0;
            stat_frames <= '0;
        end else begin
            if ((state == RUN) && s_valid && !credit_ok
                && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (drain_done) begin
                stat_frames <= stat_frames + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb_softmax_seq_ctrl: bench for the softmax frame sequencer.
// Includes a latency-LAT datapath stand-in and a queue-based output model.
module tb_softmax_seq_ctrl;

    localparam int N     = 8;
    localparam int W     = 16;
    localparam int LAT   = 8;
    localparam int DEPTH = 4;
    localparam int DW    = N * W;
    localparam logic [DW-1:0] KEY = {N{16'hA55A}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   frame_len = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          dp_en;
    logic          dp_valid_in;
    logic [DW-1:0] dp_in_x_flat;
    logic          dp_valid_out;
    logic [DW-1:0] dp_out_flat;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err_overflow;
`ifdef SOFTMAX_SEQ_STATS_EN
    logic [31:0]   stat_stall;
    logic [15:0]   stat_frames;
`endif

    softmax_seq_ctrl #(.N(N), .W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .dp_en(dp_en), .dp_valid_in(dp_valid_in),
        .dp_in_x_flat(dp_in_x_flat), .dp_valid_out(dp_valid_out),
        .dp_out_flat(dp_out_flat), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .done(done),
        .err_overflow(err_overflow)
`ifdef SOFTMAX_SEQ_STATS_EN
       ,.stat_stall(stat_stall), .stat_frames(stat_frames)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source data: unique per vector index.
    function automatic logic [DW-1:0] mk(input int idx);
        logic [DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*W +: W] = 16'(idx * 37 + j * 1001 + 5);
        return v;
    endfunction

    int src_idx = 0;
    always @(posedge clk) if (s_valid && s_ready) src_idx <= src_idx + 1;
    always_comb s_data = mk(src_idx);

    // Datapath stand-in: fixed LAT pipeline, result = input ^ KEY.
    logic          force_v = 1'b0;
    logic [LAT-1:0] pv;
    logic [DW-1:0] pd [LAT];
    always @(posedge clk) begin
        if (rst) pv <= '0;
        else pv <= {pv[LAT-2:0], dp_valid_in};
        pd[0] <= dp_in_x_flat ^ KEY;
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
    assign dp_valid_out = pv[LAT-1] | force_v;
    assign dp_out_flat  = pd[LAT-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: every issued vector is owed back, in order, LAT+1 cycles
    // after issue at the earliest; credit = issued-but-not-popped.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;
    ent_t q[$];

    bit chk_en      = 1'b0;
    bit mdl_active  = 1'b0;
    int mdl_len     = 0;
    int mdl_issued  = 0;
    int mdl_popped  = 0;
    int done_at     = -1;

    int dut_iss_cnt, dut_first_iss, dut_last_iss, dut_first_mv;
    int dut_last_pop, dut_mlast, dut_done;

    task automatic clr_stats();
        dut_iss_cnt = 0; dut_first_iss = -1; dut_last_iss = -1;
        dut_first_mv = -1; dut_last_pop = -1; dut_mlast = 0; dut_done = -1;
    endtask

    always @(negedge clk) begin
        int   outst;
        logic exp_sr, exp_iss, exp_mv, exp_ml;
        if (dp_valid_in) begin
            dut_iss_cnt++;
            if (dut_first_iss < 0) dut_first_iss = cyc;
            dut_last_iss = cyc;
        end
        if (m_valid && dut_first_mv < 0) dut_first_mv = cyc;
        if (m_valid && m_ready) dut_last_pop = cyc;
        if (m_valid && m_ready && m_last) dut_mlast++;
        if (done) dut_done = cyc;
        if (chk_en) begin
            outst   = mdl_issued - mdl_popped;
            exp_sr  = mdl_active && (mdl_issued < mdl_len) && (outst < DEPTH);
            exp_iss = s_valid && exp_sr;
            exp_mv  = 1'b0;
            if (q.size() > 0) exp_mv = (q[0].t + LAT + 1 <= cyc);
            exp_ml  = exp_mv && (mdl_popped == mdl_len - 1);
            chk("s_ready", s_ready, exp_sr);
            chk("dp_valid_in", dp_valid_in, exp_iss);
            chk("dp_in_x_flat", dp_in_x_flat, exp_iss ? s_data : '0);
            chk("dp_en", dp_en, mdl_active && (cyc != done_at));
            chk("busy", busy, mdl_active);
            chk("done", done, cyc == done_at);
            chk("m_valid", m_valid, exp_mv);
            if (exp_mv) chk("m_data", m_data, q[0].d);
            chk("m_last", m_last, exp_ml);
            chk("err_overflow", err_overflow, 1'b0);
            if (exp_mv && m_ready) begin
                void'(q.pop_front());
                mdl_popped++;
                if (mdl_popped == mdl_len) done_at = cyc + 1;
            end
            if (exp_iss) begin
                q.push_back('{d: s_data ^ KEY, t: cyc});
                mdl_issued++;
            end
            if (cyc == done_at) mdl_active = 1'b0;
        end
    end

    task automatic start_frame(input int len);
        @(posedge clk); #1;
        start = 1'b1; frame_len = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;
        mdl_len = len; mdl_issued = 0; mdl_popped = 0;
        done_at = -1; mdl_active = (len != 0);
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int k;
        for (k = 0; k < bound; k++) begin
            @(posedge clk);
            if (!mdl_active) break;
        end
        n_chk++;
        if (k == bound) begin
            n_fail++;
            $display("FAIL %s timeout act=busy exp=idle", nm);
        end
    endtask

    // Caller positions just after a posedge.
    task automatic do_reset();
        #1;
        rst = 1'b1; s_valid = 1'b0; chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mdl_active = 1'b0; mdl_issued = 0; mdl_popped = 0;
        mdl_len = 0; done_at = -1;
        @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst s_ready", s_ready, 1'b0);
        chk("rst m_valid", m_valid, 1'b0);
        chk("rst m_last", m_last, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err_overflow, 1'b0);
        chk("rst dp_en", dp_en, 1'b0);
        chk("rst m_data", m_data, '0);
        #1 chk_en = 1'b1;
    endtask

    initial begin
        clr_stats();
        // Reset state
        @(posedge clk);
        do_reset();
`ifdef SOFTMAX_SEQ_STATS_EN
        chk("rst stat_frames", stat_frames, 16'd0);
        chk("rst stat_stall", stat_stall, 32'd0);
`endif

        // 1: short frame, no backpressure
        clr_stats();
        s_valid = 1'b1; m_ready = 1'b1;
        start_frame(3);
        wait_idle(200, "t1");
        #1;
        chk("t1 issues", 32'(dut_iss_cnt), 32'd3);
        chk("t1 back-to-back", 32'(dut_last_iss - dut_first_iss), 32'd2);
        chk("t1 latency", 32'(dut_first_mv - dut_first_iss), 32'd9);
        chk("t1 m_last count", 32'(dut_mlast), 32'd1);
        chk("t1 done after pop", 32'(dut_done - dut_last_pop), 32'd1);
`ifdef SOFTMAX_SEQ_STATS_EN
        chk("t1 stat_frames", stat_frames, 16'd1);
`endif

        // 4: zero-length frame
        clr_stats();
        @(posedge clk); #1;
        chk_en = 1'b0;
        start = 1'b1; frame_len = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4 done", done, 1'b1);
        chk("t4 busy", busy, 1'b0);
        chk("t4 dp_valid_in", dp_valid_in, 1'b0);
        @(negedge clk);
        chk("t4 done pulse", done, 1'b0);
        chk("t4 busy2", busy, 1'b0);
        #1;
        chk("t4 no issue", 32'(dut_iss_cnt), 32'd0);
        chk_en = 1'b1;

        // 2: backpressure stops issue at DEPTH credits
        clr_stats();
        s_valid = 1'b1; m_ready = 1'b0;
        start_frame(10);
        repeat (30) @(posedge clk);
        #1;
        chk("t2 credit issues", 32'(dut_iss_cnt), 32'd4);
        chk("t2 s_ready", s_ready, 1'b0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle(500, "t2");
        #1;
        chk("t2 issues", 32'(dut_iss_cnt), 32'd10);
        chk("t2 m_last count", 32'(dut_mlast), 32'd1);

        // 3: spurious result while idle
        @(posedge clk); #1;
        chk_en = 1'b0;
        force_v = 1'b1;
        @(posedge clk); #1;
        force_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3 err sticky", err_overflow, 1'b1);
            chk("t3 fifo empty", m_valid, 1'b0);
        end
        @(posedge clk);
        do_reset();

        // 5: reset mid-frame, then a clean frame
        clr_stats();
        s_valid = 1'b1; m_ready = 1'b1;
        start_frame(10);
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            if (mdl_issued >= 2) break;
        end
        do_reset();
        clr_stats();
        s_valid = 1'b1;
        start_frame(5);
        wait_idle(300, "t5");
        #1;
        chk("t5 issues", 32'(dut_iss_cnt), 32'd5);
        chk("t5 m_last count", 32'(dut_mlast), 32'd1);

        // 6: random handshakes over a 64-vector frame
        clr_stats();
        start_frame(64);
        for (int k = 0; k < 4000 && mdl_active; k++) begin
            @(posedge clk); #1;
            s_valid = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0);
        end
        wait_idle(200, "t6");
        #1;
        chk("t6 issues", 32'(dut_iss_cnt), 32'd64);
        chk("t6 m_last count", 32'(dut_mlast), 32'd1);
        chk("t6 scoreboard empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
